// File: rtl/cluster_pkg.sv
// Shared cluster definitions for the merger, serializer and link formatter.
package cluster_pkg;

    localparam int unsigned MXADRBITS = 11;
    localparam int unsigned MXCNTBITS = 3;
    localparam int unsigned NSLOTS    = 8;
    localparam logic [MXADRBITS-1:0] INVALID_ADR = {MXADRBITS{1'b1}};

    typedef struct packed {
        logic [MXCNTBITS-1:0] cnt;
        logic [MXADRBITS-1:0] adr;
    } cluster_t;

endpackage

// File: rtl/first_one8.sv
// Lowest-set-bit priority encoder over 8 requests.
module first_one8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any_set
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx     = 3'd0;
        any_set = |req;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/cluster_serializer.sv
// Serializes captured cluster frames onto a framed, back-pressured stream
// through a two-bank ping-pong buffer with overflow counting.
module cluster_serializer
    import cluster_pkg::*;
#(
    parameter int unsigned MXADRBITS = cluster_pkg::MXADRBITS,
    parameter int unsigned MXCNTBITS = cluster_pkg::MXCNTBITS,
    parameter logic [MXADRBITS-1:0] INVALID_ADR = {MXADRBITS{1'b1}},
    parameter int unsigned OVFBITS   = 16
) (
    input  logic                           clock4x,
    input  logic                           reset,
    input  logic                           mux_pulse_in,
    input  logic [8*MXADRBITS-1:0]         adr_in,
    input  logic [8*MXCNTBITS-1:0]         cnt_in,
    output logic [MXADRBITS+MXCNTBITS-1:0] data_o,
    output logic                           sof_o,
    output logic                           eof_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [OVFBITS-1:0]             ovf_cnt_o,
    output logic                           ovf_o
);

    logic [MXADRBITS-1:0] adr_bank [2][8];
    logic [MXCNTBITS-1:0] cnt_bank [2][8];
    logic [7:0]           mask     [2];
    logic [1:0]           first;
    logic [1:0]           occ;
    logic                 wr_ptr;
    logic                 rd_ptr;

    logic [7:0] in_mask;
    logic [7:0] m_cur, m_oth, m_after, nxt_mask;
    logic [2:0] cur_idx, oth_idx, after_idx, nxt_idx;
    logic       cur_any, oth_any, after_any;
    logic       word_acc, bank_done, capture, drop;
    logic       load, nxt_bank, nxt_sof, nxt_eof;

    first_one8 u_fo_cur   (.req(m_cur),   .idx(cur_idx),   .any_set(cur_any));
    first_one8 u_fo_oth   (.req(m_oth),   .idx(oth_idx),   .any_set(oth_any));
    first_one8 u_fo_after (.req(m_after), .idx(after_idx), .any_set(after_any));

    // Slot validity of the incoming frame.
    always_comb begin
        in_mask = 8'd0;
        for (int k = 0; k < 8; k++) begin
            in_mask[k] = (adr_in[k*MXADRBITS +: MXADRBITS] != INVALID_ADR);
        end
    end

    // Handshake, capture/drop decisions and selection of the next output word.
    always_comb begin
        m_cur     = mask[rd_ptr];
        m_oth     = mask[~rd_ptr];
        m_after   = m_cur & (m_cur - 8'd1);
        word_acc  = valid_o & ready_i;
        bank_done = word_acc & eof_o;
        capture   = mux_pulse_in & ((occ != 2'd2) | bank_done);
        drop      = mux_pulse_in & (occ == 2'd2) & ~bank_done;

        load     = 1'b0;
        nxt_bank = rd_ptr;
        nxt_idx  = cur_idx;
        nxt_sof  = first[rd_ptr];
        nxt_mask = m_cur;
        if (!valid_o) begin
            load = (occ != 2'd0) & cur_any;
        end else if (word_acc) begin
            if (after_any) begin
                load     = 1'b1;
                nxt_idx  = after_idx;
                nxt_sof  = 1'b0;
                nxt_mask = m_after;
            end else if (occ == 2'd2) begin
                // Current bank finished; the other bank continues without a bubble.
                load     = oth_any;
                nxt_bank = ~rd_ptr;
                nxt_idx  = oth_idx;
                nxt_sof  = first[~rd_ptr];
                nxt_mask = m_oth;
            end
        end
        nxt_eof = ((nxt_mask & (nxt_mask - 8'd1)) == 8'd0);
    end

    // Banks, pointers, occupancy, output register and overflow counter.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                mask[b] <= 8'd0;
                for (int k = 0; k < 8; k++) begin
                    adr_bank[b][k] <= '0;
                    cnt_bank[b][k] <= '0;
                end
            end
            first     <= 2'b00;
            occ       <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            data_o    <= '0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            valid_o   <= 1'b0;
            ovf_cnt_o <= '0;
            ovf_o     <= 1'b0;
        end else begin
            if (word_acc) begin
                first[rd_ptr] <= 1'b0;
                mask[rd_ptr]  <= m_after;
            end
            if (bank_done) rd_ptr <= ~rd_ptr;
            // A capture into the bank being released overrides its clearing.
            if (capture) begin
                for (int k = 0; k < 8; k++) begin
                    adr_bank[wr_ptr][k] <= adr_in[k*MXADRBITS +: MXADRBITS];
                    cnt_bank[wr_ptr][k] <= cnt_in[k*MXCNTBITS +: MXCNTBITS];
                end
                if (in_mask == 8'd0) begin
                    // Empty crossing: keep one pseudo-word in slot 0 for alignment.
                    mask[wr_ptr]        <= 8'h01;
                    cnt_bank[wr_ptr][0] <= '0;
                end else begin
                    mask[wr_ptr] <= in_mask;
                end
                first[wr_ptr] <= 1'b1;
                wr_ptr        <= ~wr_ptr;
            end
            occ <= occ + 2'(capture) - 2'(bank_done);

            if (load) begin
                data_o  <= {cnt_bank[nxt_bank][nxt_idx], adr_bank[nxt_bank][nxt_idx]};
                sof_o   <= nxt_sof;
                eof_o   <= nxt_eof;
                valid_o <= 1'b1;
            end else if (word_acc) begin
                valid_o <= 1'b0;
                sof_o   <= 1'b0;
                eof_o   <= 1'b0;
            end

            if (drop) begin
                ovf_o <= 1'b1;
                if (ovf_cnt_o != {OVFBITS{1'b1}}) ovf_cnt_o <= ovf_cnt_o + OVFBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_cluster_serializer.sv
// Directed self-checking bench for cluster_serializer.
module tb_cluster_serializer;
    import cluster_pkg::*;

    localparam int unsigned DW = MXADRBITS + MXCNTBITS;

    logic                   clock4x = 1'b0;
    logic                   reset   = 1'b1;
    logic                   mux_pulse_in = 1'b0;
    logic [8*MXADRBITS-1:0] adr_in = '1;
    logic [8*MXCNTBITS-1:0] cnt_in = '0;
    logic [DW-1:0]          data_o;
    logic                   sof_o, eof_o, valid_o;
    logic                   ready_i = 1'b0;
    logic [15:0]            ovf_cnt_o;
    logic                   ovf_o;

    logic [MXADRBITS-1:0] fa [8];
    logic [MXCNTBITS-1:0] fc [8];

    int errors = 0;
    int checks = 0;

    cluster_serializer dut (
        .clock4x      (clock4x),
        .reset        (reset),
        .mux_pulse_in (mux_pulse_in),
        .adr_in       (adr_in),
        .cnt_in       (cnt_in),
        .data_o       (data_o),
        .sof_o        (sof_o),
        .eof_o        (eof_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .ovf_cnt_o    (ovf_cnt_o),
        .ovf_o        (ovf_o)
    );

    always #5 clock4x = ~clock4x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock4x);
        #1;
    endtask

    task automatic clear_frame;
        for (int k = 0; k < 8; k++) begin
            fa[k] = INVALID_ADR;
            fc[k] = '0;
        end
    endtask

    task automatic apply_frame;
        for (int k = 0; k < 8; k++) begin
            adr_in[k*MXADRBITS +: MXADRBITS] = fa[k];
            cnt_in[k*MXCNTBITS +: MXCNTBITS] = fc[k];
        end
    endtask

    task automatic expect_word(input string tag, input int a, input int c, input logic s, input logic e);
        cluster_t w;
        w.adr = MXADRBITS'(a);
        w.cnt = MXCNTBITS'(c);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".data"},  32'(data_o),  32'(w));
        check({tag, ".sof"},   32'(sof_o),   32'(s));
        check({tag, ".eof"},   32'(eof_o),   32'(e));
    endtask

    initial begin
        logic [3:0] rdy_pat;
        int j;
        rdy_pat = 4'b1001;

        // Reset state
        tick;
        tick;
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.sof", 32'(sof_o), 32'd0);
        check("rst.eof", 32'(eof_o), 32'd0);
        check("rst.data", 32'(data_o), 32'd0);
        check("rst.ovf_cnt", 32'(ovf_cnt_o), 32'd0);
        check("rst.ovf", 32'(ovf_o), 32'd0);
        reset = 1'b0;
        tick;

        // Single frame: slots 0,2,5
        clear_frame();
        fa[0] = 11'd10; fc[0] = 3'd1;
        fa[2] = 11'd20; fc[2] = 3'd2;
        fa[5] = 11'd30; fc[5] = 3'd3;
        apply_frame();
        ready_i = 1'b1;
        mux_pulse_in = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        check("single.lat0", 32'(valid_o), 32'd0);
        tick; expect_word("single.w0", 10, 1, 1'b1, 1'b0);
        tick; expect_word("single.w1", 20, 2, 1'b0, 1'b0);
        tick; expect_word("single.w2", 30, 3, 1'b0, 1'b1);
        tick; check("single.idle", 32'(valid_o), 32'd0);

        // Empty frame: counts must be forced to zero
        clear_frame();
        for (int k = 0; k < 8; k++) fc[k] = 3'd5;
        apply_frame();
        mux_pulse_in = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        tick; expect_word("empty.w", 16'h7FF, 0, 1'b1, 1'b1);
        tick; check("empty.idle", 32'(valid_o), 32'd0);

        // Back-pressure: 8 clusters, ready pattern 1,0,0,1
        clear_frame();
        for (int k = 0; k < 8; k++) begin
            fa[k] = MXADRBITS'(100 + k);
            fc[k] = MXCNTBITS'(k);
        end
        apply_frame();
        ready_i = 1'b0;
        mux_pulse_in = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        j = 0;
        for (int c = 0; c < 60 && j < 8; c++) begin
            ready_i = rdy_pat[c % 4];
            if (valid_o) begin
                expect_word("bp.w", 100 + j, j % 8, 1'(j == 0), 1'(j == 7));
                if (ready_i) j++;
            end
            tick;
        end
        check("bp.delivered", 32'(j), 32'd8);
        check("bp.idle", 32'(valid_o), 32'd0);

        // Overflow: three frames with no drain
        ready_i = 1'b0;
        clear_frame(); fa[0] = 11'd1; fc[0] = 3'd1; apply_frame();
        mux_pulse_in = 1'b1;
        tick;
        clear_frame(); fa[3] = 11'd2; fc[3] = 3'd2; apply_frame();
        tick;
        clear_frame(); fa[1] = 11'd3; fc[1] = 3'd3; apply_frame();
        tick;
        mux_pulse_in = 1'b0;
        tick;
        check("ovf.cnt", 32'(ovf_cnt_o), 32'd1);
        check("ovf.flag", 32'(ovf_o), 32'd1);
        expect_word("ovf.hold", 1, 1, 1'b1, 1'b1);
        ready_i = 1'b1;
        tick; expect_word("ovf.f1", 2, 2, 1'b1, 1'b1);
        tick; check("ovf.idle", 32'(valid_o), 32'd0);

        // Same-cycle release and capture with both banks full
        ready_i = 1'b0;
        clear_frame(); fa[0] = 11'd40; fc[0] = 3'd4; apply_frame();
        mux_pulse_in = 1'b1;
        tick;
        clear_frame(); fa[0] = 11'd50; fc[0] = 3'd5; fa[1] = 11'd51; fc[1] = 3'd6; apply_frame();
        tick;
        mux_pulse_in = 1'b0;
        tick;
        expect_word("rc.d", 40, 4, 1'b1, 1'b1);
        clear_frame(); fa[2] = 11'd60; fc[2] = 3'd7; apply_frame();
        mux_pulse_in = 1'b1;
        ready_i = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        expect_word("rc.e0", 50, 5, 1'b1, 1'b0);
        tick; expect_word("rc.e1", 51, 6, 1'b0, 1'b1);
        tick; expect_word("rc.f", 60, 7, 1'b1, 1'b1);
        tick; check("rc.idle", 32'(valid_o), 32'd0);
        check("rc.ovf_cnt", 32'(ovf_cnt_o), 32'd1);

        // Reset mid-drain, with a coincident mux pulse that must be ignored
        clear_frame();
        for (int k = 0; k < 8; k++) begin
            fa[k] = MXADRBITS'(200 + k);
            fc[k] = MXCNTBITS'(k);
        end
        apply_frame();
        mux_pulse_in = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        tick; expect_word("rst_mid.w0", 200, 0, 1'b1, 1'b0);
        tick; tick;
        expect_word("rst_mid.w2", 202, 2, 1'b0, 1'b0);
        tick;
        reset = 1'b1;
        mux_pulse_in = 1'b1;
        tick;
        check("rst_mid.valid", 32'(valid_o), 32'd0);
        check("rst_mid.ovf_cnt", 32'(ovf_cnt_o), 32'd0);
        check("rst_mid.ovf", 32'(ovf_o), 32'd0);
        reset = 1'b0;
        mux_pulse_in = 1'b0;
        tick; tick;
        check("rst_mid.ignored", 32'(valid_o), 32'd0);
        clear_frame();
        fa[4] = 11'd70; fc[4] = 3'd1;
        fa[6] = 11'd71; fc[6] = 3'd2;
        apply_frame();
        mux_pulse_in = 1'b1;
        tick;
        mux_pulse_in = 1'b0;
        tick; expect_word("fresh.w0", 70, 1, 1'b1, 1'b0);
        tick; expect_word("fresh.w1", 71, 2, 1'b0, 1'b1);
        tick; check("fresh.idle", 32'(valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cluster_serializer.md
# cluster_serializer

Transmit-side counterpart of the 16-to-8 cluster merger. On each `mux_pulse_in` it captures the eight merged clusters and discards invalid slots. It emits the remaining clusters one per `clock4x` cycle as a framed, back-pressured stream toward the optical link formatter. A two-frame ping-pong buffer lets a new bunch crossing be captured while the previous one drains; overflow is counted.

## Interface
Parameters:
- MXADRBITS, 11, cluster address width
- MXCNTBITS, 3, cluster size-count width
- INVALID_ADR, {MXADRBITS{1'b1}} (0x7FF), address marking an empty cluster slot
- OVFBITS, 16, overflow counter width

Ports:
- clock4x  in  1  sole clock, 4× bunch-crossing rate
- reset  in  1  synchronous, active-high; all state cleared on the clock4x edge where high
- mux_pulse_in  in  1  frame strobe; clusters are captured on the edge where high
- adr_in  in  8*MXADRBITS  merged cluster addresses, slot k at [k*MXADRBITS +: MXADRBITS]
- cnt_in  in  8*MXCNTBITS  merged cluster counts, same slot order
- data_o  out  MXADRBITS+MXCNTBITS  {cnt, adr} of the current word
- sof_o  out  1  first word of a frame
- eof_o  out  1  last word of a frame
- valid_o  out  1  data_o, sof_o and eof_o are valid
- ready_i  in  1  downstream accepts the word when valid_o && ready_i
- ovf_cnt_o  out  OVFBITS  saturating count of dropped frames
- ovf_o  out  1  sticky: at least one frame dropped since reset

## Operation
- Capture: when mux_pulse_in=1 and a bank is free, latch adr_in/cnt_in into the write bank.
  - Build an 8-bit pending mask: bit k = (adr slot k != INVALID_ADR).
  - Toggle the write pointer; occupancy++.
- Empty frame: if the captured mask is all-zero, the bank holds one pseudo-word with adr=INVALID_ADR, cnt=0, sof=eof=1. This preserves bunch-crossing alignment downstream.
- Drain: the read bank presents the lowest-index pending slot via a priority encoder.
  - sof_o=1 on the first word of the bank; eof_o=1 when the mask has exactly one bit left.
  - On accept, clear that mask bit.
  - On accept of the eof word, release the bank: read pointer toggles, occupancy--.
- Order: slots leave strictly in ascending index; frames leave in capture order.
- Handshake: once valid_o is high it stays high, and data_o/sof_o/eof_o stay stable, until accepted. valid_o never depends combinationally on ready_i.
- Overflow: mux_pulse_in=1 with both banks occupied and no same-cycle release means the frame is dropped.
  - ovf_cnt_o increments, saturating at all-ones; ovf_o is set.
  - Stored banks are untouched.
- Simultaneous capture and release (eof accepted in the same cycle): the capture succeeds and occupancy is unchanged.
- mux_pulse_in asserted on consecutive cycles: each assertion is an independent capture attempt.

## Timing
- Reset values: valid_o=0, sof_o=0, eof_o=0, data_o=0, ovf_cnt_o=0, ovf_o=0, both banks empty, both pointers 0.
- Latency: capture at edge N into an empty buffer gives valid_o=1 at edge N+1, with the first word registered.
- Throughput: one word per cycle while ready_i=1, including back-to-back frames with no bubble between eof and the next sof.
  - A full 8-cluster frame drains in 8 cycles.
  - At the nominal rate of one mux_pulse per 4 cycles, more than 4 valid clusters per crossing sustained causes overflow; this is intended.
- Reset asserted mid-frame: on the next edge valid_o=0 and all banks are discarded. A mux_pulse_in coincident with reset is ignored.
- ovf_cnt_o/ovf_o update on the edge after the dropped pulse.

## Structure
- Shared package `cluster_pkg`, also used by the merger and the link formatter:
  - MXADRBITS, MXCNTBITS, INVALID_ADR
  - typedef `cluster_t` {cnt, adr}
- Sub-module `first_one8`: combinational 8-bit lowest-set-bit priority encoder with 3-bit index output and any-set output.
- Everything else (banks, pointers, occupancy, output register, overflow counter) is in the top level.

## Test plan
- Single frame: slots 0,2,5 valid with adr 10,20,30 and cnt 1,2,3, others 0x7FF, ready_i=1. Expect words adr 10/20/30 on cycles N+1..N+3; sof on 10, eof on 30; valid_o low at N+4.
- Empty frame: all slots 0x7FF. Expect one word adr=0x7FF, cnt=0, sof=eof=1 at N+1.
- Back-pressure: 8 valid clusters, ready_i toggling 1,0,0,1… Expect data held stable while ready_i=0, all 8 delivered in order, no duplicates.
- Overflow: ready_i=0, three mux_pulses with valid frames. Expect ovf_cnt_o=1 and ovf_o=1. Then ready_i=1: only the first two frames emerge, in order.
- Same-cycle release and capture: both banks full, eof accepted on the cycle of mux_pulse_in. Expect no overflow and the new frame emitted after the remaining bank.
- Reset mid-drain after word 3 of 8: expect valid_o=0 on the next edge, ovf_cnt_o=0, and a fresh frame after reset starting with sof.
